// File: rtl/fetch_prefetch.sv
// Instruction fetch stage: issues sequential reads to a 1-cycle synchronous
// instruction memory and buffers the responses in a small prefetch queue that
// decode drains over a valid/ready handshake. Redirect and halt flush both the
// queue and any response still in flight.
module fetch_prefetch #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter int              DEPTH    = 4,
  parameter int              INC      = 1,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redir,
  input  logic [PC_W-1:0]            redir_pc,
  input  logic                       halt,
  input  logic [PC_W-1:0]            halt_pc,
  output logic                       imem_req,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]         imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [PC_W-1:0]            out_pc,
  output logic [PC_W-1:0]            out_pc_inc,
  output logic                       halted,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int              CW    = $clog2(DEPTH + 1);
  localparam int              AW    = $clog2(DEPTH);
  localparam logic [PC_W-1:0] INC_V = PC_W'(INC);

  typedef enum logic [1:0] {ST_START, ST_RUN, ST_HALTED} state_t;

  state_t              state, state_next;
  logic [PC_W-1:0]     fetch_pc;
  logic                inflight;
  logic [PC_W-1:0]     inflight_pc;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic [INSTR_W-1:0]  q_instr [DEPTH];
  logic [PC_W-1:0]     q_pc    [DEPTH];

  logic flush, room, enq, deq, head_valid;

  // Requests in flight count against capacity so a response always has a slot.
  assign room = ({1'b0, count} + {{CW{1'b0}}, inflight}) < (CW + 1)'(DEPTH);

  assign head_valid = (count != '0);
  assign enq        = inflight & ~flush;
  assign deq        = head_valid & out_ready & ~flush;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_START;
    else      state <= state_next;
  end

  // Next state, flush decision and issue gate; halt outranks redirect.
  always_comb begin
    state_next = state;
    flush      = 1'b0;
    imem_req   = 1'b0;
    case (state)
      ST_START: begin
        state_next = ST_RUN;
        if (halt) begin
          state_next = ST_HALTED;
          flush      = 1'b1;
        end else if (redir) begin
          flush = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_next = ST_HALTED;
          flush      = 1'b1;
        end else if (redir) begin
          flush = 1'b1;
        end else begin
          imem_req = room;
        end
      end
      default: ;
    endcase
  end

  // Fetch PC, in-flight tracking and queue pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      inflight    <= imem_req;
      inflight_pc <= fetch_pc;
      if (flush) begin
        fetch_pc <= halt ? halt_pc : redir_pc;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (imem_req) fetch_pc <= fetch_pc + INC_V;
        if (enq) wr_ptr <= wr_ptr + AW'(1);
        if (deq) rd_ptr <= rd_ptr + AW'(1);
        case ({enq, deq})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage; only pointers need reset since reads are gated by count.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= inflight_pc;
    end
  end

  assign imem_addr  = fetch_pc;
  assign out_valid  = head_valid;
  assign out_instr  = head_valid ? q_instr[rd_ptr] : '0;
  assign out_pc     = head_valid ? q_pc[rd_ptr] : '0;
  assign out_pc_inc = head_valid ? q_pc[rd_ptr] + INC_V : '0;
  assign halted     = (state == ST_HALTED);
  assign occupancy  = count;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_prefetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, redir, halt, out_ready;
  logic [15:0] redir_pc, halt_pc;
  logic        imem_req, out_valid, halted;
  logic [15:0] imem_addr, imem_rdata, out_instr, out_pc, out_pc_inc;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  fetch_prefetch dut (
    .clk(clk), .rst(rst), .redir(redir), .redir_pc(redir_pc),
    .halt(halt), .halt_pc(halt_pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_inc(out_pc_inc), .halted(halted), .occupancy(occupancy)
  );

  // Synchronous instruction memory: mem[a] = A000 + a.
  always @(posedge clk) if (imem_req) imem_rdata <= 16'hA000 + imem_addr;

  // Narrow-PC instance for wraparound.
  logic        rst8, req8, valid8, halted8;
  logic [7:0]  addr8, pc8, pcinc8;
  logic [15:0] rdata8, instr8;
  logic [2:0]  occ8;

  fetch_prefetch #(.PC_W(8), .RESET_PC(8'hFE)) dut8 (
    .clk(clk), .rst(rst8), .redir(1'b0), .redir_pc(8'h00),
    .halt(1'b0), .halt_pc(8'h00), .imem_req(req8),
    .imem_addr(addr8), .imem_rdata(rdata8), .out_valid(valid8),
    .out_ready(1'b1), .out_instr(instr8), .out_pc(pc8),
    .out_pc_inc(pcinc8), .halted(halted8), .occupancy(occ8)
  );

  always @(posedge clk) if (req8) rdata8 <= 16'hA000 + {8'h00, addr8};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of PCs awaiting decode plus the one outstanding read.
  bit          m_run, m_halt, m_infl;
  logic [15:0] m_pc, m_ipc;
  logic [15:0] q[$];

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_imem_req", imem_req, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_out_pc_inc", out_pc_inc, 0);
      m_run = 0; m_halt = 0; m_infl = 0; m_pc = 16'h0000; m_ipc = 16'h0000;
      q.delete();
    end else begin : model_step
      bit          flush, req, valid;
      logic [15:0] e_instr, e_inc;
      flush = !m_halt && (halt || redir);
      req   = m_run && !m_halt && !halt && !redir && (q.size() + int'(m_infl) < 4);
      valid = (q.size() != 0);
      chk("imem_req", imem_req, req);
      chk("imem_addr", imem_addr, m_pc);
      chk("out_valid", out_valid, valid);
      chk("halted", halted, m_halt);
      chk("occupancy", occupancy, q.size());
      if (valid) begin
        e_instr = 16'hA000 + q[0];
        e_inc   = q[0] + 16'd1;
        chk("out_pc", out_pc, q[0]);
        chk("out_instr", out_instr, e_instr);
        chk("out_pc_inc", out_pc_inc, e_inc);
      end
      if (valid && out_ready && !flush) begin
        $display("xfer pc=%h instr=%h pc_inc=%h", out_pc, out_instr, out_pc_inc);
        void'(q.pop_front());
      end
      if (m_infl && !flush) q.push_back(m_ipc);
      if (flush) q.delete();
      m_ipc  = m_pc;
      m_infl = req;
      if (!m_halt) begin
        if (halt) begin
          m_pc   = halt_pc;
          m_halt = 1;
        end else if (redir) begin
          m_pc = redir_pc;
        end else if (req) begin
          m_pc = m_pc + 16'd1;
        end
        m_run = 1;
      end
    end
  end

  logic [7:0] pcs [4];
  logic [7:0] incs [4];
  logic [15:0] first_instr8;
  int n8;
  bit found;

  initial begin
    rst = 0; rst8 = 0; redir = 0; halt = 0; out_ready = 1;
    redir_pc = 16'h0000; halt_pc = 16'h0000;
    repeat (3) cyc();

    // Reset release: request one cycle later, first output two cycles after that.
    rst = 1;
    cyc();
    chk("t1_req_first", imem_req, 1);
    chk("t1_addr_first", imem_addr, 16'h0000);
    cyc(); cyc();
    chk("t1_valid", out_valid, 1);
    chk("t1_instr", out_instr, 16'hA000);
    chk("t1_pc", out_pc, 16'h0000);
    chk("t1_pc_inc", out_pc_inc, 16'h0001);
    cyc();
    chk("t1_pc_next", out_pc, 16'h0001);
    repeat (5) cyc();

    // Backpressure fills the queue and stops issue.
    out_ready = 0;
    repeat (10) cyc();
    chk("t2_occ_full", occupancy, 4);
    chk("t2_req_stop", imem_req, 0);
    out_ready = 1;
    repeat (12) cyc();

    // Redirect with three entries queued and one read in flight.
    out_ready = 0;
    repeat (10) cyc();
    out_ready = 1;
    cyc();
    out_ready = 0;
    cyc();
    chk("t3_occ_before", occupancy, 3);
    redir = 1; redir_pc = 16'h0040; out_ready = 1;
    cyc();
    redir = 0;
    chk("t3_occ_after", occupancy, 0);
    chk("t3_valid_after", out_valid, 0);
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      cyc();
      if (out_valid) begin
        found = 1;
        chk("t3_first_pc", out_pc, 16'h0040);
      end
    end
    chk("t3_found", found, 1);
    repeat (4) cyc();

    // Halt and redirect together: halt wins; afterwards both are ignored.
    halt = 1; redir = 1; halt_pc = 16'h00FF; redir_pc = 16'h0010;
    cyc();
    halt = 0; redir = 0;
    chk("t4_halted", halted, 1);
    chk("t4_addr", imem_addr, 16'h00FF);
    chk("t4_valid", out_valid, 0);
    repeat (3) cyc();
    redir = 1; redir_pc = 16'h0123;
    cyc();
    redir = 0; halt = 1; halt_pc = 16'h0AAA;
    cyc();
    halt = 0;
    repeat (3) cyc();
    chk("t4_addr_held", imem_addr, 16'h00FF);
    chk("t4_still_halted", halted, 1);
    chk("t4_no_valid", out_valid, 0);

    // Asynchronous reset mid-stream.
    rst = 0;
    cyc();
    rst = 1;
    repeat (8) cyc();
    chk("t6_streaming", out_valid, 1);
    #2 rst = 0;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_occ", occupancy, 0);
    chk("t6_async_req", imem_req, 0);
    chk("t6_async_pc", out_pc, 0);
    cyc();
    rst = 1;
    cyc(); cyc(); cyc();
    chk("t6_restart_valid", out_valid, 1);
    chk("t6_restart_pc", out_pc, 16'h0000);
    repeat (4) cyc();

    // Narrow PC wraps FE, FF, 00, 01.
    chk("t5_rst_valid", valid8, 0);
    chk("t5_rst_occ", occ8, 0);
    rst8 = 1;
    n8 = 0;
    first_instr8 = 16'h0000;
    for (int i = 0; i < 20 && n8 < 4; i++) begin
      @(negedge clk);
      if (valid8) begin
        if (n8 == 0) first_instr8 = instr8;
        pcs[n8]  = pc8;
        incs[n8] = pcinc8;
        $display("xfer8 pc=%h instr=%h pc_inc=%h", pc8, instr8, pcinc8);
        n8++;
      end
    end
    chk("t5_count", n8, 4);
    chk("t5_halted", halted8, 0);
    chk("t5_instr0", first_instr8, 16'hA0FE);
    chk("t5_pc0", pcs[0], 8'hFE);
    chk("t5_pc1", pcs[1], 8'hFF);
    chk("t5_pc2", pcs[2], 8'h00);
    chk("t5_pc3", pcs[3], 8'h01);
    chk("t5_inc_ff", incs[1], 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
